pattern_gen: RTL and testbench

Test-pattern generator directly downstream of the sync/timing generator. It consumes that stage's `vs`/`hs`/`de`/`field` strobes and `x`/`y` active-area coordinates and produces 24-bit RGB pixels. All timing strobes are re-emitted delayed to stay aligned with the pixels. The output feeds the TMDS/HDMI encoder front end.

---
 rtl/pattern_gen.sv | 255 +++++++++++++++++++++++++
 tb/tb_pattern_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen.sv
// -----------------------------------------------------------------------------
// pattern_gen
//
// Test-pattern generator placed after the video timing generator. It turns the
// timing strobes and active-area coordinates into 24-bit RGB pixels. The
// strobes are re-emitted with the same 2-cycle delay as the pixels so the
// downstream TMDS encoder sees aligned data.
//
// Ports
//   clk, reset        pixel clock, synchronous active-high reset
//   pattern_sel       requested pattern, latched at frame start only
//   solid_rgb         {R,G,B} colour for the solid pattern
//   bar_w             pixels per colour bar
//   h_active          active pixels per line (moving-bar wrap point)
//   vs/hs/de/field_in timing strobes, active-high
//   x_in, y_in        active-area coordinates
//   vs/hs/de/field_out strobes delayed by 2 cycles
//   r/g/b_out         pixel colour, forced to 0 outside active video
//   pattern_active    pattern currently in effect
//
// Pipeline
//   stage 1: register strobes, per-pixel selectors (bar index, checker bit,
//            moving-bar hit, ramp value, solid colour) and pattern in effect
//   stage 2: colour mux and blanking into the output registers
// -----------------------------------------------------------------------------
module pattern_gen #(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        pattern_sel,
  input  logic [23:0]       solid_rgb,
  input  logic [X_BITS-1:0] bar_w,
  input  logic [X_BITS-1:0] h_active,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  input  logic              field_in,
  input  logic [X_BITS-1:0] x_in,
  input  logic [Y_BITS:0]   y_in,
  output logic              vs_out,
  output logic              hs_out,
  output logic              de_out,
  output logic              field_out,
  output logic [7:0]        r_out,
  output logic [7:0]        g_out,
  output logic [7:0]        b_out,
  output logic [2:0]        pattern_active
);

  localparam int XW1 = X_BITS + 1;

  localparam logic [2:0] PAT_SOLID   = 3'd0;
  localparam logic [2:0] PAT_BARS    = 3'd1;
  localparam logic [2:0] PAT_RAMP    = 3'd2;
  localparam logic [2:0] PAT_CHECKER = 3'd3;
  localparam logic [2:0] PAT_MOVING  = 3'd4;

  localparam logic [X_BITS-1:0] X_ONE    = X_BITS'(1);
  localparam logic [XW1-1:0]    POS_STEP = XW1'(4);
  localparam logic [XW1-1:0]    BAR_LEN  = XW1'(16);
  localparam logic [23:0]       WHITE    = 24'hFFFFFF;
  localparam logic [23:0]       BLACK    = 24'h000000;

  // Colour for each of the eight bars, left to right.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF; // white
      3'd1:    c = 24'hFFFF00; // yellow
      3'd2:    c = 24'h00FFFF; // cyan
      3'd3:    c = 24'h00FF00; // green
      3'd4:    c = 24'hFF00FF; // magenta
      3'd5:    c = 24'hFF0000; // red
      3'd6:    c = 24'h0000FF; // blue
      default: c = 24'h000000; // black
    endcase
    return c;
  endfunction

  // Frame-level state
  logic              vs_prev_q, vs_prev_d;
  logic [2:0]        pattern_active_q, pattern_active_d;
  logic [X_BITS-1:0] pos_q, pos_d;
  logic [X_BITS-1:0] bar_px_q, bar_px_d;
  logic [2:0]        bar_idx_q, bar_idx_d;

  // Stage 1
  logic        vs_s1_q, vs_s1_d, hs_s1_q, hs_s1_d;
  logic        de_s1_q, de_s1_d, field_s1_q, field_s1_d;
  logic [2:0]  pat_s1_q, pat_s1_d;
  logic [2:0]  bar_idx_s1_q, bar_idx_s1_d;
  logic        checker_s1_q, checker_s1_d;
  logic        hit_s1_q, hit_s1_d;
  logic [7:0]  ramp_s1_q, ramp_s1_d;
  logic [23:0] solid_s1_q, solid_s1_d;

  // Stage 2 (outputs)
  logic        vs_out_q, vs_out_d, hs_out_q, hs_out_d;
  logic        de_out_q, de_out_d, field_out_q, field_out_d;
  logic [23:0] rgb_q, rgb_d;

  logic              frame_start_s;
  logic [2:0]        pat_eff_s;
  logic [XW1-1:0]    pos_sum_s;
  logic [XW1-1:0]    pos_end_s;
  logic [XW1-1:0]    x_ext_s;

  // Only y bit 4 drives the checkerboard; the rest is intentionally ignored.
  logic unused_y_s;
  assign unused_y_s = ^{y_in[Y_BITS:5], y_in[3:0]};

  // Frame start detection, pattern latch and moving-bar position update.
  always_comb begin
    frame_start_s = vs_in & ~vs_prev_q;
    vs_prev_d     = vs_in;
    // The pixel arriving on the frame-start cycle already uses the new pattern.
    if (frame_start_s) begin
      pat_eff_s = pattern_sel;
    end else begin
      pat_eff_s = pattern_active_q;
    end
    pattern_active_d = pat_eff_s;
    pos_sum_s = {1'b0, pos_q} + POS_STEP;
    if (frame_start_s) begin
      if (pos_sum_s >= {1'b0, h_active}) begin
        pos_d = {X_BITS{1'b0}};
      end else begin
        pos_d = pos_sum_s[X_BITS-1:0];
      end
    end else begin
      pos_d = pos_q;
    end
  end

  // Colour-bar counters: restart every line, saturate on the last bar.
  always_comb begin
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (!de_in) begin
      bar_px_d  = {X_BITS{1'b0}};
      bar_idx_d = 3'd0;
    end else if (bar_w == {X_BITS{1'b0}}) begin
      // Zero-width bars would never complete; keep the whole line white.
      bar_px_d  = {X_BITS{1'b0}};
      bar_idx_d = 3'd0;
    end else if (bar_px_q == (bar_w - X_ONE)) begin
      bar_px_d = {X_BITS{1'b0}};
      if (bar_idx_q == 3'd7) begin
        bar_idx_d = 3'd7;
      end else begin
        bar_idx_d = bar_idx_q + 3'd1;
      end
    end else begin
      bar_px_d  = bar_px_q + X_ONE;
      bar_idx_d = bar_idx_q;
    end
  end

  // Stage 1: capture strobes and per-pixel pattern selectors.
  always_comb begin
    vs_s1_d      = vs_in;
    hs_s1_d      = hs_in;
    de_s1_d      = de_in;
    field_s1_d   = field_in;
    pat_s1_d     = pat_eff_s;
    bar_idx_s1_d = bar_idx_q;
    checker_s1_d = x_in[4] ^ y_in[4];
    ramp_s1_d    = x_in[7:0];
    solid_s1_d   = solid_rgb;
    // Compare one bit wider so pos+16 cannot wrap past the line end.
    x_ext_s      = {1'b0, x_in};
    pos_end_s    = {1'b0, pos_q} + BAR_LEN;
    hit_s1_d     = (x_ext_s >= {1'b0, pos_q}) && (x_ext_s < pos_end_s);
  end

  // Stage 2: colour mux and blanking.
  always_comb begin
    vs_out_d    = vs_s1_q;
    hs_out_d    = hs_s1_q;
    de_out_d    = de_s1_q;
    field_out_d = field_s1_q;
    case (pat_s1_q)
      PAT_SOLID:   rgb_d = solid_s1_q;
      PAT_BARS:    rgb_d = bar_colour(bar_idx_s1_q);
      PAT_RAMP:    rgb_d = {ramp_s1_q, ramp_s1_q, ramp_s1_q};
      PAT_CHECKER: rgb_d = checker_s1_q ? WHITE : BLACK;
      PAT_MOVING:  rgb_d = hit_s1_q ? WHITE : BLACK;
      default:     rgb_d = BLACK;
    endcase
    if (!de_s1_q) begin
      rgb_d = BLACK;
    end else begin
      rgb_d = rgb_d;
    end
  end

  // All state and pipeline registers, synchronous reset to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev_q        <= 1'b0;
      pattern_active_q <= 3'd0;
      pos_q            <= {X_BITS{1'b0}};
      bar_px_q         <= {X_BITS{1'b0}};
      bar_idx_q        <= 3'd0;
      vs_s1_q          <= 1'b0;
      hs_s1_q          <= 1'b0;
      de_s1_q          <= 1'b0;
      field_s1_q       <= 1'b0;
      pat_s1_q         <= 3'd0;
      bar_idx_s1_q     <= 3'd0;
      checker_s1_q     <= 1'b0;
      hit_s1_q         <= 1'b0;
      ramp_s1_q        <= 8'd0;
      solid_s1_q       <= 24'd0;
      vs_out_q         <= 1'b0;
      hs_out_q         <= 1'b0;
      de_out_q         <= 1'b0;
      field_out_q      <= 1'b0;
      rgb_q            <= 24'd0;
    end else begin
      vs_prev_q        <= vs_prev_d;
      pattern_active_q <= pattern_active_d;
      pos_q            <= pos_d;
      bar_px_q         <= bar_px_d;
      bar_idx_q        <= bar_idx_d;
      vs_s1_q          <= vs_s1_d;
      hs_s1_q          <= hs_s1_d;
      de_s1_q          <= de_s1_d;
      field_s1_q       <= field_s1_d;
      pat_s1_q         <= pat_s1_d;
      bar_idx_s1_q     <= bar_idx_s1_d;
      checker_s1_q     <= checker_s1_d;
      hit_s1_q         <= hit_s1_d;
      ramp_s1_q        <= ramp_s1_d;
      solid_s1_q       <= solid_s1_d;
      vs_out_q         <= vs_out_d;
      hs_out_q         <= hs_out_d;
      de_out_q         <= de_out_d;
      field_out_q      <= field_out_d;
      rgb_q            <= rgb_d;
    end
  end

  assign vs_out         = vs_out_q;
  assign hs_out         = hs_out_q;
  assign de_out         = de_out_q;
  assign field_out      = field_out_q;
  assign r_out          = rgb_q[23:16];
  assign g_out          = rgb_q[15:8];
  assign b_out          = rgb_q[7:0];
  assign pattern_active = pattern_active_q;

endmodule

// File: tb/tb_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_pattern_gen
//
// Directed bench for pattern_gen: a vector table for the stateless patterns
// plus hand-written sequences for reset, latency, colour bars, mid-frame
// pattern change and the moving bar.
// -----------------------------------------------------------------------------
module tb_pattern_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  pattern_sel;
  logic [23:0] solid_rgb;
  logic [11:0] bar_w;
  logic [11:0] h_active;
  logic        vs_in, hs_in, de_in, field_in;
  logic [11:0] x_in;
  logic [12:0] y_in;
  logic        vs_out, hs_out, de_out, field_out;
  logic [7:0]  r_out, g_out, b_out;
  logic [2:0]  pattern_active;

  int errors = 0;
  int checks = 0;

  pattern_gen #(.X_BITS(12), .Y_BITS(12)) dut (
    .clk(clk), .reset(reset), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .bar_w(bar_w), .h_active(h_active), .vs_in(vs_in), .hs_in(hs_in),
    .de_in(de_in), .field_in(field_in), .x_in(x_in), .y_in(y_in),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out), .field_out(field_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .pattern_active(pattern_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  pat;
    logic [23:0] solid;
    logic [11:0] x;
    logic [12:0] y;
    logic        de;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t vecs[11];
  logic [23:0] bar_tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] rgb();
    return {r_out, g_out, b_out};
  endfunction

  // Blanked vs_in low cycle then a rising edge carrying the new selection.
  task automatic set_pattern(input logic [2:0] p);
    vs_in = 1'b0; de_in = 1'b0;
    tick();
    vs_in = 1'b1; pattern_sel = p;
    tick();
    check($sformatf("pat_latch_%0d", p), {29'd0, pattern_active}, {29'd0, p});
    vs_in = 1'b0;
  endtask

  initial begin
    logic [3:0]  hist[14];
    logic [3:0]  s;
    logic [2:0]  idx;
    logic [23:0] exp;
    logic [23:0] mid_exp[5];
    int          m_pos;
    int          p;

    bar_tbl[0] = 24'hFFFFFF; bar_tbl[1] = 24'hFFFF00; bar_tbl[2] = 24'h00FFFF;
    bar_tbl[3] = 24'h00FF00; bar_tbl[4] = 24'hFF00FF; bar_tbl[5] = 24'hFF0000;
    bar_tbl[6] = 24'h0000FF; bar_tbl[7] = 24'h000000;

    vecs[0]  = '{pat:3'd0, solid:24'h123456, x:12'd0,    y:13'd0,  de:1'b1, exp_rgb:24'h123456};
    vecs[1]  = '{pat:3'd0, solid:24'h123456, x:12'd0,    y:13'd0,  de:1'b0, exp_rgb:24'h000000};
    vecs[2]  = '{pat:3'd2, solid:24'h123456, x:12'h105,  y:13'd0,  de:1'b1, exp_rgb:24'h050505};
    vecs[3]  = '{pat:3'd2, solid:24'h123456, x:12'h0FF,  y:13'd0,  de:1'b1, exp_rgb:24'hFFFFFF};
    vecs[4]  = '{pat:3'd3, solid:24'h123456, x:12'd16,   y:13'd0,  de:1'b1, exp_rgb:24'hFFFFFF};
    vecs[5]  = '{pat:3'd3, solid:24'h123456, x:12'd16,   y:13'd16, de:1'b1, exp_rgb:24'h000000};
    vecs[6]  = '{pat:3'd3, solid:24'h123456, x:12'd0,    y:13'd0,  de:1'b1, exp_rgb:24'h000000};
    vecs[7]  = '{pat:3'd3, solid:24'h123456, x:12'd3,    y:13'd17, de:1'b1, exp_rgb:24'hFFFFFF};
    vecs[8]  = '{pat:3'd5, solid:24'h123456, x:12'd7,    y:13'd0,  de:1'b1, exp_rgb:24'h000000};
    vecs[9]  = '{pat:3'd7, solid:24'hFFFFFF, x:12'd7,    y:13'd0,  de:1'b1, exp_rgb:24'h000000};
    vecs[10] = '{pat:3'd0, solid:24'hA5C33C, x:12'd9,    y:13'd3,  de:1'b1, exp_rgb:24'hA5C33C};

    // ---------------- reset with random inputs ----------------
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pattern_sel = 3'($urandom); solid_rgb = 24'($urandom);
      bar_w = 12'($urandom); h_active = 12'($urandom);
      {vs_in, hs_in, de_in, field_in} = 4'($urandom);
      x_in = 12'($urandom); y_in = 13'($urandom);
      tick();
    end
    check("rst_strobes", {28'd0, vs_out, hs_out, de_out, field_out}, 32'd0);
    check("rst_rgb", {8'd0, rgb()}, 32'd0);
    check("rst_pattern", {29'd0, pattern_active}, 32'd0);

    // Release with de=1, sel=2, no vs edge: solid pattern stays in effect.
    reset = 1'b0; vs_in = 1'b0; hs_in = 1'b0; field_in = 1'b0; de_in = 1'b1;
    pattern_sel = 3'd2; solid_rgb = 24'h336699; bar_w = 12'd4; h_active = 12'd0;
    x_in = 12'd5; y_in = 13'd0;
    tick(); tick();
    check("post_rst_rgb", {8'd0, rgb()}, {8'd0, 24'h336699});
    check("post_rst_pattern", {29'd0, pattern_active}, 32'd0);
    vs_in = 1'b1;
    tick();
    check("first_vs_pattern", {29'd0, pattern_active}, 32'd2);
    vs_in = 1'b0;

    // ---------------- latency / alignment ----------------
    set_pattern(3'd0);
    pattern_sel = 3'd0; solid_rgb = 24'h0A0B0C;
    hist = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'hF, 4'hE, 4'hD, 4'hB, 4'h7, 4'h5, 4'hA, 4'h3, 4'hC};
    for (int j = 0; j <= 14; j++) begin
      if (j < 14) s = hist[j]; else s = 4'h0;
      {vs_in, hs_in, de_in, field_in} = s;
      tick();
      if (j >= 1) begin
        check($sformatf("lat_strobes_%0d", j - 1),
              {28'd0, vs_out, hs_out, de_out, field_out}, {28'd0, hist[j-1]});
        exp = hist[j-1][1] ? 24'h0A0B0C : 24'h000000;
        check($sformatf("lat_rgb_%0d", j - 1), {8'd0, rgb()}, {8'd0, exp});
      end
    end
    {vs_in, hs_in, de_in, field_in} = 4'h0;

    // ---------------- table-driven stateless patterns ----------------
    for (int v = 0; v < 11; v++) begin
      if (v == 0 || vecs[v].pat != vecs[v-1].pat) set_pattern(vecs[v].pat);
      solid_rgb = vecs[v].solid; x_in = vecs[v].x; y_in = vecs[v].y; de_in = vecs[v].de;
      tick(); tick();
      check($sformatf("vec%0d_rgb", v), {8'd0, rgb()}, {8'd0, vecs[v].exp_rgb});
      check($sformatf("vec%0d_de", v), {31'd0, de_out}, {31'd0, vecs[v].de});
    end

    // ---------------- colour bars, bar_w = 4 then 0 ----------------
    set_pattern(3'd1);
    for (int run = 0; run < 2; run++) begin
      bar_w = (run == 0) ? 12'd4 : 12'd0;
      for (int i = 0; i <= 40; i++) begin
        x_in = 12'(i); de_in = (i < 40);
        tick();
        if (i >= 1) begin
          p = i - 1;
          idx = (p / 4 > 7) ? 3'd7 : 3'(p / 4);
          exp = (run == 0) ? bar_tbl[idx] : 24'hFFFFFF;
          check($sformatf("bars_w%0d_px%0d", (run == 0) ? 4 : 0, p), {8'd0, rgb()}, {8'd0, exp});
        end
      end
    end
    de_in = 1'b0;

    // ---------------- mid-frame select change ----------------
    set_pattern(3'd0);
    solid_rgb = 24'h102030; bar_w = 12'd2;
    for (int i = 0; i <= 8; i++) begin
      pattern_sel = (i < 3) ? 3'd0 : 3'd1;
      x_in = 12'(i); de_in = (i < 8);
      tick();
      if (i >= 1) check($sformatf("mid_solid_px%0d", i - 1), {8'd0, rgb()}, {8'd0, 24'h102030});
    end
    check("mid_pattern_held", {29'd0, pattern_active}, 32'd0);
    vs_in = 1'b0; de_in = 1'b0;
    tick();
    mid_exp = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00, 24'h00FFFF};
    for (int i = 0; i <= 5; i++) begin
      vs_in = (i == 0); de_in = (i < 5); x_in = 12'(i);
      tick();
      if (i == 0) check("next_frame_pattern", {29'd0, pattern_active}, 32'd1);
      else check($sformatf("next_frame_px%0d", i - 1), {8'd0, rgb()}, {8'd0, mid_exp[i-1]});
    end
    vs_in = 1'b0; de_in = 1'b0;

    // ---------------- moving bar, h_active = 20 ----------------
    // h_active was 0 at every earlier frame start, so pos is 0 here.
    h_active = 12'd20; m_pos = 0;
    for (int f = 0; f < 6; f++) begin
      set_pattern(3'd4);
      m_pos = (m_pos + 4 >= 20) ? 0 : m_pos + 4;
      for (int i = 0; i <= 20; i++) begin
        x_in = 12'(i); de_in = (i < 20);
        tick();
        if (i >= 1) begin
          p = i - 1;
          exp = (p >= m_pos && p < m_pos + 16) ? 24'hFFFFFF : 24'h000000;
          check($sformatf("mbar_f%0d_pos%0d_x%0d", f, m_pos, p), {8'd0, rgb()}, {8'd0, exp});
        end
      end
    end
    de_in = 1'b0;

    // ---------------- reset mid-frame ----------------
    de_in = 1'b1; x_in = 12'd3;
    reset = 1'b1;
    tick();
    check("midrst_rgb", {8'd0, rgb()}, 32'd0);
    check("midrst_de", {31'd0, de_out}, 32'd0);
    check("midrst_pattern", {29'd0, pattern_active}, 32'd0);
    reset = 1'b0; solid_rgb = 24'h0F1E2D; vs_in = 1'b0;
    tick(); tick();
    check("midrst_refill_rgb", {8'd0, rgb()}, {8'd0, 24'h0F1E2D});
    check("midrst_refill_de", {31'd0, de_out}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
